// File: rtl/regfile_scoreboard_if.sv
// Register file bus: decode-side reads/reservations and writeback writes.
// Decode/writeback side drives as master; the register file is the slave.
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid;
  logic              busy_a;
  logic              busy_b;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              pending_any;

  modport master (
    output wr_en, wr_addr, wr_data,
    output rd_en, rd_addr_a, rd_addr_b,
    output rsv_en, rsv_addr,
    input  rd_data_a, rd_data_b, rd_valid,
    input  busy_a, busy_b, pending_any
  );

  modport slave (
    input  wr_en, wr_addr, wr_data,
    input  rd_en, rd_addr_a, rd_addr_b,
    input  rsv_en, rsv_addr,
    output rd_data_a, rd_data_b, rd_valid,
    output busy_a, busy_b, pending_any
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// 2R1W register file with write-first forwarding and per-register pending bits.
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_scoreboard #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 4,
  parameter int NUM_REGS = 16
) (
  input logic                clock,
  input logic                reset,
  regfile_scoreboard_if.slave bus
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;

  logic [DATA_W-1:0] rd_data_a_q;
  logic [DATA_W-1:0] rd_data_b_q;
  logic              rd_valid_q;
  logic              busy_a_q;
  logic              busy_b_q;
  logic              pending_any_q;

  logic              wr_ok;
  logic              rsv_ok;
  logic [DATA_W-1:0] rd_nxt_a;
  logic [DATA_W-1:0] rd_nxt_b;
  logic              busy_nxt_a;
  logic              busy_nxt_b;

  function automatic logic in_rng(input logic [ADDR_W-1:0] a);
    return int'(a) < NUM_REGS;
  endfunction

  // Addresses that may be written or reserved
  function automatic logic mutable(input logic [ADDR_W-1:0] a);
`ifdef REGFILE_ZERO_REG_EN
    return in_rng(a) && (a != '0);
`else
    return in_rng(a);
`endif
  endfunction

  assign wr_ok  = bus.wr_en  && mutable(bus.wr_addr);
  assign rsv_ok = bus.rsv_en && mutable(bus.rsv_addr);

  // Reserve applied after write so a new producer wins
  always_comb begin
    pending_next = pending;
    if (wr_ok)
      pending_next[bus.wr_addr] = 1'b0;
    if (rsv_ok)
      pending_next[bus.rsv_addr] = 1'b1;
  end

  always_comb begin
    rd_nxt_a   = '0;
    rd_nxt_b   = '0;
    busy_nxt_a = 1'b0;
    busy_nxt_b = 1'b0;
    if (in_rng(bus.rd_addr_a)) begin
      rd_nxt_a = (wr_ok && bus.wr_addr == bus.rd_addr_a)
               ? bus.wr_data : regs[bus.rd_addr_a];
      busy_nxt_a = pending_next[bus.rd_addr_a];
    end
    if (in_rng(bus.rd_addr_b)) begin
      rd_nxt_b = (wr_ok && bus.wr_addr == bus.rd_addr_b)
               ? bus.wr_data : regs[bus.rd_addr_b];
      busy_nxt_b = pending_next[bus.rd_addr_b];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
      pending       <= '0;
      pending_any_q <= 1'b0;
      rd_data_a_q   <= '0;
      rd_data_b_q   <= '0;
      rd_valid_q    <= 1'b0;
      busy_a_q      <= 1'b0;
      busy_b_q      <= 1'b0;
    end else begin
      if (wr_ok)
        regs[bus.wr_addr] <= bus.wr_data;
      pending       <= pending_next;
      pending_any_q <= |pending_next;
      rd_valid_q    <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_a_q <= rd_nxt_a;
        rd_data_b_q <= rd_nxt_b;
        busy_a_q    <= busy_nxt_a;
        busy_b_q    <= busy_nxt_b;
      end
    end
  end

  assign bus.rd_data_a   = rd_data_a_q;
  assign bus.rd_data_b   = rd_data_b_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.busy_a      = busy_a_q;
  assign bus.busy_b      = busy_b_q;
  assign bus.pending_any = pending_any_q;

endmodule
